// File: rtl/store_buffer_if.sv
// Store buffer port bundle: store intake, load forwarding probe, memory write port, status.
// master = memory access stage / memory side, slave = the store buffer itself.
interface store_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [BE_WIDTH-1:0]   st_be;

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_fwd_hit;
  logic [DATA_WIDTH-1:0] ld_fwd_data;
  logic                  ld_conflict;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [BE_WIDTH-1:0]   mem_req_be;

  logic [CNT_WIDTH-1:0]  count;
  logic                  empty;
  logic                  full;

  modport master (
    output st_valid, st_addr, st_wdata, st_be, ld_valid, ld_addr, mem_req_ready,
    input  st_ready, ld_fwd_hit, ld_fwd_data, ld_conflict,
    input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_be, count, empty, full
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, ld_valid, ld_addr, mem_req_ready,
    output st_ready, ld_fwd_hit, ld_fwd_data, ld_conflict,
    output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_be, count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// Circular-FIFO store buffer draining committed stores to memory, with load hazard check.
// Define STORE_BUFFER_FORWARD_EN to build per-byte forwarding; otherwise any match stalls the load.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [PTR_W-1:0]      headPtr, tailPtr;
  logic [PTR_W-1:0]      occupancy;
  logic [ADDR_WIDTH-1:0] entAddr [DEPTH];
  logic [DATA_WIDTH-1:0] entData [DEPTH];
  logic [BE_WIDTH-1:0]   entBe   [DEPTH];
  logic                  isEmpty, isFull, enqFire, deqFire, ldActive;

  assign occupancy = tailPtr - headPtr;
  assign isEmpty   = (headPtr == tailPtr);
  assign isFull    = (headPtr[IDX_W-1:0] == tailPtr[IDX_W-1:0]) &&
                     (headPtr[IDX_W] != tailPtr[IDX_W]);

  assign sb.st_ready      = rst && !isFull;
  assign sb.mem_req_valid = rst && !isEmpty;
  assign enqFire          = sb.st_valid && sb.st_ready;
  assign deqFire          = sb.mem_req_valid && sb.mem_req_ready;

  assign sb.mem_req_addr  = entAddr[headPtr[IDX_W-1:0]];
  assign sb.mem_req_wdata = entData[headPtr[IDX_W-1:0]];
  assign sb.mem_req_be    = entBe[headPtr[IDX_W-1:0]];
  assign sb.count         = occupancy;
  assign sb.empty         = isEmpty;
  assign sb.full          = isFull;

  // Entry payloads need no reset: validity is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      if (enqFire) begin
        entAddr[tailPtr[IDX_W-1:0]] <= sb.st_addr;
        entData[tailPtr[IDX_W-1:0]] <= sb.st_wdata;
        entBe[tailPtr[IDX_W-1:0]]   <= sb.st_be;
        tailPtr <= tailPtr + PTR_W'(1);
      end
      if (deqFire) headPtr <= headPtr + PTR_W'(1);
    end
  end

  assign ldActive = rst && sb.ld_valid;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [BE_WIDTH-1:0]   covered;
  logic [DATA_WIDTH-1:0] merged;
  logic [IDX_W-1:0]      slot;

  // Walk oldest to youngest so younger entries overwrite older lanes.
  always_comb begin
    covered = '0;
    merged  = '0;
    slot    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = headPtr[IDX_W-1:0] + IDX_W'(k);
      if ((PTR_W'(k) < occupancy) && (entAddr[slot] == sb.ld_addr)) begin
        covered = covered | entBe[slot];
        for (int b = 0; b < BE_WIDTH; b++)
          if (entBe[slot][b]) merged[8*b +: 8] = entData[slot][8*b +: 8];
      end
    end
  end

  assign sb.ld_fwd_hit  = ldActive && (&covered);
  assign sb.ld_conflict = ldActive && (|covered) && !(&covered);
  assign sb.ld_fwd_data = sb.ld_fwd_hit ? merged : '0;
`else
  logic              matchAny;
  logic [IDX_W-1:0]  slot;

  always_comb begin
    matchAny = 1'b0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = headPtr[IDX_W-1:0] + IDX_W'(k);
      if ((PTR_W'(k) < occupancy) && (entAddr[slot] == sb.ld_addr)) matchAny = 1'b1;
    end
  end

  assign sb.ld_fwd_hit  = 1'b0;
  assign sb.ld_conflict = ldActive && matchAny;
  assign sb.ld_fwd_data = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic against a queue model.
// Follows STORE_BUFFER_FORWARD_EN the same way the design does.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  int   totalCount = 0;
  int   failCount  = 0;
  entry_t modelQ[$];

  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sbIf ();
  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbIf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per lane, the youngest buffered store to the load address that enables that lane supplies it.
  task automatic modelLoad(output logic hit, output logic conflict, output logic [DW-1:0] data);
    logic [BW-1:0] covered;
    logic          anyMatch;
    hit = 0; conflict = 0; data = '0; covered = '0; anyMatch = 0;
    if (rst && sbIf.ld_valid) begin
      foreach (modelQ[i]) if (modelQ[i].addr == sbIf.ld_addr) anyMatch = 1;
      for (int b = 0; b < BW; b++) begin
        for (int i = modelQ.size() - 1; i >= 0; i--) begin
          if (modelQ[i].addr == sbIf.ld_addr && modelQ[i].be[b]) begin
            data[8*b +: 8] = modelQ[i].data[8*b +: 8];
            covered[b] = 1;
            break;
          end
        end
      end
`ifdef STORE_BUFFER_FORWARD_EN
      hit      = (covered == {BW{1'b1}});
      conflict = (covered != '0) && !hit;
      if (!hit) data = '0;
`else
      conflict = anyMatch;
      data     = '0;
`endif
    end
  endtask

  task automatic doCycle();
    logic          expHit, expConf, enqFire, deqFire;
    logic [DW-1:0] expData;
    entry_t        incoming;
    @(negedge clk);
    modelLoad(expHit, expConf, expData);
    check("count", sbIf.count, modelQ.size());
    check("empty", sbIf.empty, modelQ.size() == 0);
    check("full", sbIf.full, modelQ.size() == DEPTH);
    check("st_ready", sbIf.st_ready, rst && modelQ.size() < DEPTH);
    check("mem_req_valid", sbIf.mem_req_valid, rst && modelQ.size() > 0);
    if (rst && modelQ.size() > 0) begin
      check("mem_req_addr", sbIf.mem_req_addr, modelQ[0].addr);
      check("mem_req_wdata", sbIf.mem_req_wdata, modelQ[0].data);
      check("mem_req_be", sbIf.mem_req_be, modelQ[0].be);
    end
    check("ld_fwd_hit", sbIf.ld_fwd_hit, expHit);
    check("ld_conflict", sbIf.ld_conflict, expConf);
    if (expHit || !rst || !sbIf.ld_valid) check("ld_fwd_data", sbIf.ld_fwd_data, expData);
    enqFire  = rst && sbIf.st_valid && modelQ.size() < DEPTH;
    deqFire  = rst && sbIf.mem_req_ready && modelQ.size() > 0;
    incoming = '{addr: sbIf.st_addr, data: sbIf.st_wdata, be: sbIf.st_be};
    @(posedge clk);
    if (!rst) modelQ.delete();
    else begin
      if (deqFire) void'(modelQ.pop_front());
      if (enqFire) modelQ.push_back(incoming);
    end
    #1;
  endtask

  task automatic setStore(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
    sbIf.st_valid = v; sbIf.st_addr = a; sbIf.st_wdata = d; sbIf.st_be = be;
  endtask

  initial begin
    rst = 0;
    setStore(0, '0, '0, '0);
    sbIf.ld_valid = 0; sbIf.ld_addr = '0; sbIf.mem_req_ready = 0;
    @(posedge clk); #1;
    doCycle();
    rst = 1;
    sbIf.mem_req_ready = 1;
    repeat (2) doCycle();

    // Fill past capacity with memory stalled, then drain in order.
    sbIf.mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      setStore(1, AW'(32'h10 + i), 32'hA000_0000 + i, 4'hF);
      if (i == 4) begin
        @(negedge clk);
        check("fifth_st_ready", sbIf.st_ready, 0);
        check("fifth_full", sbIf.full, 1);
        @(posedge clk); #1;
      end else doCycle();
    end
    setStore(0, '0, '0, '0);
    doCycle();
    sbIf.mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_addr", sbIf.mem_req_addr, 32'h10 + i);
      @(posedge clk); #1;
      void'(modelQ.pop_front());
    end
    doCycle();
    check("drained_empty", sbIf.empty, 1);

    // Steady state at count==1 with pointer wrap.
    setStore(1, AW'(32'h50), 32'h5000_0000, 4'hF);
    doCycle();
    for (int i = 1; i <= 8; i++) begin
      setStore(1, AW'(32'h50 + i), 32'h5000_0000 + i, 4'hF);
      doCycle();
    end
    setStore(0, '0, '0, '0);
    doCycle();
    check("steady_count", sbIf.count, 0);

    // Forwarding: full word then a low-byte overwrite to the same address.
    sbIf.mem_req_ready = 0;
    setStore(1, AW'(32'h20), 32'h1122_3344, 4'hF); doCycle();
    setStore(1, AW'(32'h20), 32'h0000_00AA, 4'h1); doCycle();
    setStore(0, '0, '0, '0);
    sbIf.ld_valid = 1; sbIf.ld_addr = AW'(32'h20);
    @(negedge clk);
`ifdef STORE_BUFFER_FORWARD_EN
    check("fwd_hit", sbIf.ld_fwd_hit, 1);
    check("fwd_data", sbIf.ld_fwd_data, 32'h1122_33AA);
    check("fwd_conflict", sbIf.ld_conflict, 0);
`else
    check("nofwd_conflict", sbIf.ld_conflict, 1);
    check("nofwd_hit", sbIf.ld_fwd_hit, 0);
`endif
    @(posedge clk); #1;
    sbIf.ld_addr = AW'(32'h21);
    doCycle();
    sbIf.ld_valid = 0;
    doCycle();

    // Partial coverage only.
    sbIf.mem_req_ready = 1;
    repeat (3) doCycle();
    sbIf.mem_req_ready = 0;
    setStore(1, AW'(32'h30), 32'h0000_BEEF, 4'h3); doCycle();
    setStore(0, '0, '0, '0);
    sbIf.ld_valid = 1; sbIf.ld_addr = AW'(32'h30);
    @(negedge clk);
    check("partial_conflict", sbIf.ld_conflict, 1);
    check("partial_hit", sbIf.ld_fwd_hit, 0);
    @(posedge clk); #1;
    sbIf.ld_valid = 0;

    // Reset with stores pending discards them.
    for (int i = 0; i < 2; i++) begin
      setStore(1, AW'(32'h60 + i), 32'h6000_0000 + i, 4'hF); doCycle();
    end
    setStore(0, '0, '0, '0);
    doCycle();
    check("pre_reset_count", sbIf.count, 3);
    rst = 0;
    doCycle();
    rst = 1;
    sbIf.mem_req_ready = 1;
    doCycle();
    check("post_reset_count", sbIf.count, 0);
    check("post_reset_empty", sbIf.empty, 1);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      setStore(1'($urandom_range(0, 1)), AW'(32'h40 + $urandom_range(0, 3)), $urandom,
               BW'($urandom_range(0, 15)));
      sbIf.ld_valid      = 1'($urandom_range(0, 1));
      sbIf.ld_addr       = AW'(32'h40 + $urandom_range(0, 4));
      sbIf.mem_req_ready = ($urandom_range(0, 2) == 0);
      rst                = ($urandom_range(0, 99) != 0);
      doCycle();
    end

    $display("%0d/%0d checks passed", totalCount - failCount, totalCount);
    $finish;
  end
endmodule
